// File: rtl/rtc_time_setter.sv
// rtc_time_setter
//   Button-driven time-set controller on the write side of the RTC time
//   registers. A mode press preloads the live BCD time into a shadow copy.
//   Further mode presses step through hours, minutes and seconds, and the
//   inc button edits the active field. The final mode press presents the
//   shadow time to the RTC over a valid/ready load handshake.
//
// Optional feature: define RTC_SET_DEC_EN to add the btn_dec button, which
//   decrements the active field with BCD borrow and wrap.
//
// Ports
//   clk              system clock, all logic on posedge
//   rst              synchronous, active-low reset
//   btn_mode         raw mode button (active high, already synchronised)
//   btn_inc          raw increment button (active high, already synchronised)
//   btn_dec          raw decrement button (only with RTC_SET_DEC_EN)
//   cur_*            live RTC BCD digits, preload source
//   load_ready       RTC accepts the load this cycle
//   load_valid       shadow time presented on set_*
//   set_*            shadow BCD digits (hours/minutes/seconds, tens/units)
//   field            0=none, 1=hours, 2=minutes, 3=seconds
//   editing          high in SET_HRS, SET_MIN, SET_SEC and COMMIT
//   blink            toggles every BLINK_DIV cycles while editing, else 0
module rtc_time_setter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_DIV       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
`ifdef RTC_SET_DEC_EN
  input  logic       btn_dec,
`endif
  input  logic [3:0] cur_sec_l,
  input  logic [3:0] cur_sec_m,
  input  logic [3:0] cur_min_l,
  input  logic [3:0] cur_min_m,
  input  logic [3:0] cur_hrs_l,
  input  logic [3:0] cur_hrs_m,
  input  logic       load_ready,
  output logic       load_valid,
  output logic [3:0] set_sec_l,
  output logic [3:0] set_sec_m,
  output logic [3:0] set_min_l,
  output logic [3:0] set_min_m,
  output logic [3:0] set_hrs_l,
  output logic [3:0] set_hrs_m,
  output logic [1:0] field,
  output logic       editing,
  output logic       blink
);

`ifdef RTC_SET_DEC_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [2:0] {IDLE, SET_HRS, SET_MIN, SET_SEC, COMMIT} state_t;

  state_t          state;
  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   deb_lvl;
  logic [NB-1:0]   pulse;
  logic [CW-1:0]   deb_cnt [NB];
  logic [BW-1:0]   blink_cnt;
  logic            mode_p;
  logic            inc_act;
  logic            edit_act;
  logic [3:0]      sel_m;
  logic [3:0]      sel_l;
  logic [3:0]      max_m;
  logic [3:0]      max_l;
  logic [7:0]      edit_pair;

  // Increment one BCD field. Units >= 9 (including non-BCD) wrap to 0 and
  // carry; a result above max_m:max_l, or with an overflowing tens digit,
  // folds to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] m, input logic [3:0] l,
                                         input logic [3:0] mx_m, input logic [3:0] mx_l);
    logic [4:0] nm;
    logic [3:0] nl;
    if (l >= 4'd9) begin
      nl = 4'd0;
      nm = {1'b0, m} + 5'd1;
    end else begin
      nl = l + 4'd1;
      nm = {1'b0, m};
    end
    if (nm > {1'b0, mx_m} || (nm == {1'b0, mx_m} && nl > mx_l))
      return 8'h00;
    return {nm[3:0], nl};
  endfunction

`ifdef RTC_SET_DEC_EN
  // Decrement one BCD field. 00 wraps to the field maximum; units 0 borrow
  // from tens; non-BCD units are treated as 9 after the step; anything still
  // out of range folds to the maximum.
  function automatic logic [7:0] bcd_dec(input logic [3:0] m, input logic [3:0] l,
                                         input logic [3:0] mx_m, input logic [3:0] mx_l);
    logic [3:0] nm;
    logic [3:0] nl;
    if (m == 4'd0 && l == 4'd0)
      return {mx_m, mx_l};
    if (l == 4'd0) begin
      nl = 4'd9;
      nm = m - 4'd1;
    end else if (l > 4'd9) begin
      nl = 4'd9;
      nm = m;
    end else begin
      nl = l - 4'd1;
      nm = m;
    end
    if (nm > mx_m || (nm == mx_m && nl > mx_l))
      return {mx_m, mx_l};
    return {nm, nl};
  endfunction
`endif

`ifdef RTC_SET_DEC_EN
  assign btn_raw  = {btn_dec, btn_inc, btn_mode};
  logic dec_act;
  // Simultaneous inc and dec cancel; mode always wins.
  assign inc_act  = pulse[1] & ~pulse[2] & ~pulse[0];
  assign dec_act  = pulse[2] & ~pulse[1] & ~pulse[0];
  assign edit_act = inc_act | dec_act;
`else
  assign btn_raw  = {btn_inc, btn_mode};
  // Mode always wins over a same-cycle inc.
  assign inc_act  = pulse[1] & ~pulse[0];
  assign edit_act = inc_act;
`endif
  assign mode_p = pulse[0];

  // Debounce: count consecutive samples that differ from the accepted level;
  // accept on the DEBOUNCE_CYCLES-th one. A rising acceptance emits a single
  // pulse, so a held button never repeats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_lvl <= '0;
      pulse   <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (btn_raw[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
          pulse[i]   <= 1'b0;
        end else if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          deb_lvl[i] <= btn_raw[i];
          pulse[i]   <= btn_raw[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
          pulse[i]   <= 1'b0;
        end
      end
    end
  end

  // Select the active field and compute its edited value.
  always_comb begin
    sel_m = set_sec_m;
    sel_l = set_sec_l;
    max_m = 4'd5;
    max_l = 4'd9;
    case (state)
      SET_HRS: begin
        sel_m = set_hrs_m;
        sel_l = set_hrs_l;
        max_m = 4'd2;
        max_l = 4'd3;
      end
      SET_MIN: begin
        sel_m = set_min_m;
        sel_l = set_min_l;
      end
      default: ;
    endcase
    edit_pair = {sel_m, sel_l};
    if (inc_act)
      edit_pair = bcd_inc(sel_m, sel_l, max_m, max_l);
`ifdef RTC_SET_DEC_EN
    else if (dec_act)
      edit_pair = bcd_dec(sel_m, sel_l, max_m, max_l);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      load_valid <= 1'b0;
      field      <= 2'd0;
      editing    <= 1'b0;
      blink      <= 1'b0;
      blink_cnt  <= '0;
      set_sec_l  <= 4'd0;
      set_sec_m  <= 4'd0;
      set_min_l  <= 4'd0;
      set_min_m  <= 4'd0;
      set_hrs_l  <= 4'd0;
      set_hrs_m  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          load_valid <= 1'b0;
          field      <= 2'd0;
          editing    <= 1'b0;
          if (mode_p) begin
            set_sec_l <= cur_sec_l;
            set_sec_m <= cur_sec_m;
            set_min_l <= cur_min_l;
            set_min_m <= cur_min_m;
            set_hrs_l <= cur_hrs_l;
            set_hrs_m <= cur_hrs_m;
            state     <= SET_HRS;
            field     <= 2'd1;
            editing   <= 1'b1;
          end
        end
        SET_HRS: begin
          if (mode_p) begin
            state <= SET_MIN;
            field <= 2'd2;
          end else if (edit_act) begin
            {set_hrs_m, set_hrs_l} <= edit_pair;
          end
        end
        SET_MIN: begin
          if (mode_p) begin
            state <= SET_SEC;
            field <= 2'd3;
          end else if (edit_act) begin
            {set_min_m, set_min_l} <= edit_pair;
          end
        end
        SET_SEC: begin
          if (mode_p) begin
            state      <= COMMIT;
            field      <= 2'd0;
            load_valid <= 1'b1;
          end else if (edit_act) begin
            {set_sec_m, set_sec_l} <= edit_pair;
          end
        end
        COMMIT: begin
          // Shadow digits are frozen here; only the handshake can leave.
          if (load_ready) begin
            state      <= IDLE;
            load_valid <= 1'b0;
            editing    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Blink runs only while editing and restarts from 0 on every entry.
      if (state == IDLE || (state == COMMIT && load_ready)) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_setter.sv
// Testbench for rtc_time_setter: random and directed button sequences are
// applied; a behavioural model tracks the expected shadow time and mode, and
// each committed time is queued for a monitor that checks the load transfer.
module tb_rtc_time_setter;
  localparam int D = 4;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
`ifdef RTC_SET_DEC_EN
  logic       btn_dec = 1'b0;
`endif
  logic [23:0] cur = 24'h0;
  logic       load_ready = 1'b0;
  logic       load_valid;
  logic [3:0] set_sec_l, set_sec_m, set_min_l, set_min_m, set_hrs_l, set_hrs_m;
  logic [1:0] field;
  logic       editing;
  logic       blink;
  logic [23:0] dut_time;

  assign dut_time = {set_hrs_m, set_hrs_l, set_min_m, set_min_l, set_sec_m, set_sec_l};

  rtc_time_setter #(.DEBOUNCE_CYCLES(D), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
`ifdef RTC_SET_DEC_EN
    .btn_dec(btn_dec),
`endif
    .cur_sec_l(cur[3:0]), .cur_sec_m(cur[7:4]), .cur_min_l(cur[11:8]),
    .cur_min_m(cur[15:12]), .cur_hrs_l(cur[19:16]), .cur_hrs_m(cur[23:20]),
    .load_ready(load_ready), .load_valid(load_valid),
    .set_sec_l(set_sec_l), .set_sec_m(set_sec_m), .set_min_l(set_min_l),
    .set_min_m(set_min_m), .set_hrs_l(set_hrs_l), .set_hrs_m(set_hrs_m),
    .field(field), .editing(editing), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];

  // Model: mode 0=idle, 1=hours, 2=minutes, 3=seconds, 4=commit.
  int mmode = 0;
  int md[6];   // hrs tens, hrs units, min tens, min units, sec tens, sec units

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_time();
    logic [23:0] t;
    for (int k = 0; k < 6; k++) t[23-4*k -: 4] = 4'(md[k]);
    return t;
  endfunction

  task automatic model_mode();
    case (mmode)
      0: begin
        for (int k = 0; k < 6; k++) md[k] = int'(cur[23-4*k -: 4]);
        mmode = 1;
      end
      1, 2: mmode = mmode + 1;
      3: begin
        mmode = 4;
        exp_q.push_back(model_time());
      end
      default: ;
    endcase
  endtask

  task automatic model_inc();
    int m, l, mx, ix;
    if (mmode < 1 || mmode > 3) return;
    ix = (mmode - 1) * 2;
    mx = (mmode == 1) ? 23 : 59;
    m = md[ix];
    l = md[ix+1];
    if (l >= 9) begin l = 0; m = m + 1; end else l = l + 1;
    if (m * 10 + l > mx) begin m = 0; l = 0; end
    md[ix] = m;
    md[ix+1] = l;
  endtask

  // Monitor: every accepted load is popped from the scoreboard and compared;
  // while a load is pending the presented time must match and stay stable.
  always @(negedge clk) begin
    if (rst && load_valid) begin
      if (load_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL xfer_unexpected: got %0h expected no transfer", dut_time);
        end else begin
          check("xfer_time", int'(dut_time), int'(exp_q.pop_front()));
        end
      end else if (exp_q.size() != 0) begin
        check("hold_time", int'(dut_time), int'(exp_q[0]));
      end
    end
  end

  task automatic check_all(input string tag);
    check({tag, "_field"}, int'(field), (mmode >= 1 && mmode <= 3) ? mmode : 0);
    check({tag, "_editing"}, int'(editing), (mmode != 0) ? 1 : 0);
    check({tag, "_valid"}, int'(load_valid), (mmode == 4) ? 1 : 0);
    check({tag, "_time"}, int'(dut_time), int'(model_time()));
  endtask

  // One clean press: held long enough to debounce, then released long enough.
  task automatic press(input bit m, input bit i);
    @(posedge clk); #1;
    btn_mode = m;
    btn_inc  = i;
    repeat (D + 2) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (D + 2) @(posedge clk);
    if (m) model_mode();
    else if (i) model_inc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mmode = 0;
    for (int k = 0; k < 6; k++) md[k] = 0;
    @(negedge clk);
  endtask

  task automatic commit(input int wait_cycles);
    for (int k = 0; k < wait_cycles; k++) @(negedge clk);
    check("commit_wait_valid", int'(load_valid), 1);
    @(posedge clk); #1;
    load_ready = 1'b1;
    @(posedge clk); #1;
    load_ready = 1'b0;
    mmode = 0;
    @(negedge clk);
    check("commit_drained", exp_q.size(), 0);
    check_all("after_commit");
  endtask

  task automatic enter(input logic [23:0] t);
    cur = t;
    press(1, 0);
    check_all("preload");
  endtask

  initial begin
    int toggles;
    logic prev;
    for (int k = 0; k < 6; k++) md[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all("reset");
    check("reset_blink", int'(blink), 0);

    // Reset mid-COMMIT clears everything without a transfer.
    cur = 24'h123456;
    press(1, 0); press(1, 0); press(1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    mmode = 0;
    for (int k = 0; k < 6; k++) md[k] = 0;
    @(negedge clk);
    check_all("rst_commit");

    // Bounce shorter than the debounce window, then one clean press.
    enter(24'h055000);
    @(posedge clk); #1;
    btn_inc = 1'b1; repeat (D - 1) @(posedge clk); #1;
    btn_inc = 1'b0; @(posedge clk); #1;
    btn_inc = 1'b1; repeat (D - 2) @(posedge clk); #1;
    btn_inc = 1'b0; repeat (D + 4) @(posedge clk);
    @(negedge clk);
    check_all("bounce");
    press(0, 1);
    check_all("clean_inc");

    // Blink toggles exactly twice over 2*B cycles while editing.
    toggles = 0;
    prev = blink;
    for (int k = 0; k < 2 * B; k++) begin
      @(negedge clk);
      if (blink != prev) toggles++;
      prev = blink;
    end
    check("blink_toggles", toggles, 2);
    press(1, 0); press(1, 0); press(1, 0);
    commit(0);
    check("idle_blink", int'(blink), 0);

    // Wrap cases from 23:59:58.
    enter(24'h235958);
    press(0, 1); check_all("hrs_wrap");
    press(1, 0); press(0, 1); check_all("min_wrap");
    press(1, 0); press(0, 1); check_all("sec_inc");
    press(1, 0);
    commit(3);

    // Hours 09 -> 10, 19 -> 20, minutes 49 -> 50, mode+inc together.
    enter(24'h094900);
    press(0, 1); check_all("h09");
    press(1, 0); press(1, 1); check_all("mode_wins");
    press(1, 0); commit(1);
    enter(24'h194912);
    press(0, 1); check_all("h19");
    press(1, 0); press(0, 1); check_all("m49");
    press(1, 0); press(1, 0);
    // Long stall: inc and mode pulses in COMMIT are ignored.
    press(0, 1); press(1, 0);
    check_all("commit_ignore");
    commit(10);

    // Inc in IDLE is ignored.
    press(0, 1);
    check_all("idle_inc");

`ifdef RTC_SET_DEC_EN
    enter(24'h000000);
    @(posedge clk); #1;
    btn_dec = 1'b1; repeat (D + 2) @(posedge clk); #1;
    btn_dec = 1'b0; repeat (D + 2) @(posedge clk);
    @(negedge clk);
    check("dec_hrs_wrap", int'({set_hrs_m, set_hrs_l}), 8'h23);
    do_reset();
`endif

    // Randomised sessions, including non-BCD preloads.
    for (int it = 0; it < 20; it++) begin
      logic [23:0] t;
      if ($urandom_range(0, 3) == 0) t = 24'($urandom);
      else begin
        t[23:20] = 4'($urandom_range(0, 2));
        t[19:16] = (t[23:20] == 4'd2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9));
        t[15:12] = 4'($urandom_range(0, 5));
        t[11:8]  = 4'($urandom_range(0, 9));
        t[7:4]   = 4'($urandom_range(0, 5));
        t[3:0]   = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0) press(0, 1);
      enter(t);
      for (int f = 0; f < 3; f++) begin
        int n;
        n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++) press(0, 1);
        check_all("rnd_field");
        press(1, 0);
      end
      if ($urandom_range(0, 1) == 0) press($urandom_range(0, 1) == 1, 1);
      commit($urandom_range(0, 12));
      if (it == 10) do_reset();
    end

    do_reset();
    check_all("final_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog bound for the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
